mmcam_match_ctrl: RTL and testbench
===================================

Name: mmcam_match_ctrl

Overview:
- Controller for the matching-memory CAM stage of the data-driven pipeline.
- Pairs token packets that share a key (color, generation, destination) but carry opposite L/R operand bits.
- Owns a DEPTH-entry waiting store. Each arriving token is searched against all valid entries.
  - Hit: frees the partner entry and emits a fired operand pair downstream.
  - Miss: allocates a free entry for the token.
- Sits between the token input queue and the firing/instruction-fetch stage.

Parameters:
- DEPTH, 8, number of waiting entries (power of 2, 2..64).
- KEY_W, 18, key width: color + generation + destination.
- DATA_W, 16, operand data width.

Ports:
- CP  in  1  clock, rising edge.
- MR  in  1  master reset, asynchronous, active-low.
- IN_VALID  in  1  input token present.
- IN_READY  out  1  controller accepts the token this cycle.
- IN_KEY  in  KEY_W  token key.
- IN_LR  in  1  operand side: 0 = L, 1 = R.
- IN_DATA  in  DATA_W  operand value.
- OUT_VALID  out  1  fired pair available.
- OUT_READY  in  1  downstream accepts the pair.
- OUT_KEY  out  KEY_W  key of the fired pair.
- OUT_DATA_L  out  DATA_W  L operand.
- OUT_DATA_R  out  DATA_W  R operand.
- FLUSH  in  1  synchronous clear of all entries. Only honoured in IDLE.
- OVF_CLR  in  1  clears the OVERFLOW flag.
- OVERFLOW  out  1  sticky: a token was dropped because the store was full.
- COUNT  out  clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Reset (MR=0, async):
  - FSM goes to IDLE and all entry valid bits clear.
  - IN_READY=0 during reset, 1 in the first IDLE cycle after release.
  - OUT_VALID=0, OUT_KEY/OUT_DATA_L/OUT_DATA_R=0, OVERFLOW=0, COUNT=0.
  - Entry key/data contents need no reset.
- FSM states: IDLE, LOOKUP, FIRE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID: capture key/LR/data into the holding register and go to LOOKUP.
  - FLUSH (only when IN_VALID=0): clear all valid bits and COUNT next cycle. FLUSH with IN_VALID=1: the token is accepted and FLUSH is ignored.
- LOOKUP (IN_READY=0):
  - Hit condition: entry valid && key equal && LR differs. All entries are compared in parallel.
  - Multiple hits: the lowest index wins.
  - Hit:
    - Load OUT_KEY.
    - OUT_DATA_L/OUT_DATA_R come from the token and the entry, ordered by LR.
    - Clear the hit entry's valid bit; COUNT decrements.
    - Go to FIRE.
  - Miss with a free entry: write the token into the lowest-index free entry, set valid, COUNT increments, go to IDLE.
  - Miss with the store full: drop the token, set OVERFLOW, go to IDLE.
  - A same-key, same-LR token is a miss. It is stored as a separate entry, never overwritten.
- FIRE (IN_READY=0):
  - OUT_VALID=1. Outputs stay stable until OUT_VALID && OUT_READY.
  - On handshake: OUT_VALID=0 next cycle, go to IDLE.
- Latency and throughput:
  - Token accepted at edge N; result decided at edge N+1.
  - Hit: OUT_VALID visible after edge N+1, so the earliest downstream handshake is at edge N+2.
  - Miss: throughput is 1 token per 2 cycles.
  - Hit with OUT_READY held high: 1 token per 3 cycles.
- OVERFLOW:
  - Cleared by OVF_CLR=1 in any state.
  - If OVF_CLR and a new overflow occur in the same cycle, the set wins.
- All outputs are registered except IN_READY, which is decoded directly from the FSM state.
- Reset asserted mid-operation:
  - Any pending fired pair is lost.
  - The held token is discarded.
  - The store empties.

Decomposition:
- Shared package mmcam_pkg:
  - Token field widths/offsets: color, gen, dest, LR bit.
  - FSM state encoding: IDLE=2'd0, LOOKUP=2'd1, FIRE=2'd2.
  - Typedef for a store entry {valid, key, lr, data}.
- Sub-module mmcam_pri_enc: parameterised lowest-index-first priority encoder.
  - Outputs an index and a found flag.
  - Instantiated twice: once for hit selection, once for free-entry selection.

Test Plan:
1. Reset then single pair:
   - Send key=0x00A5, LR=0, data=0x1111 → COUNT=1, no OUT_VALID.
   - Send key=0x00A5, LR=1, data=0x2222 → OUT_VALID 2 cycles after accept, OUT_DATA_L=0x1111, OUT_DATA_R=0x2222, COUNT=0.
2. Non-match:
   - Send key=0x0001 L, then key=0x0002 R → no fire, COUNT=2.
   - Send key=0x0001 LR=0 again → stored as a third entry, COUNT=3.
3. Full/overflow:
   - Fill 8 distinct L tokens → COUNT=8.
   - Ninth distinct token → dropped, OVERFLOW=1, COUNT=8.
   - Matching R for entry 3 → fires, COUNT=7.
   - OVF_CLR → OVERFLOW=0.
4. Priority:
   - Store key=0x0010 L with data=0xAAAA, then key=0x0010 L with data=0xBBBB.
   - Send R → OUT_DATA_L=0xAAAA (lowest index), COUNT=1.
5. Backpressure: hold OUT_READY=0 for 5 cycles during a fire → outputs stable, IN_READY=0 throughout; release → single handshake, then IDLE.
6. Async reset and FLUSH:
   - Pull MR low in FIRE → OUT_VALID=0 immediately, COUNT=0.
   - Separately, FLUSH in IDLE with 4 entries stored → COUNT=0 next cycle.

Source files
------------

// File: rtl/mmcam_pkg.sv
`default_nettype none
// ============================================================================
// Package : mmcam_pkg
// Brief   : Shared token layout, FSM encoding and store entry type for the
//           matching-memory CAM stage.
// Revision: 1.0 - initial release
// ============================================================================
package mmcam_pkg;

  localparam int C_COLOR_W = 6;
  localparam int C_GEN_W   = 4;
  localparam int C_DEST_W  = 8;
  localparam int C_KEY_W   = C_COLOR_W + C_GEN_W + C_DEST_W;
  localparam int C_DATA_W  = 16;

  // Key field offsets inside the key: {color, gen, dest}
  localparam int C_DEST_LSB  = 0;
  localparam int C_GEN_LSB   = C_DEST_LSB + C_DEST_W;
  localparam int C_COLOR_LSB = C_GEN_LSB + C_GEN_W;

  // Token packet layout: {lr, key, data}
  localparam int C_TOK_DATA_LSB = 0;
  localparam int C_TOK_KEY_LSB  = C_TOK_DATA_LSB + C_DATA_W;
  localparam int C_TOK_LR_BIT   = C_TOK_KEY_LSB + C_KEY_W;
  localparam int C_TOK_W        = C_TOK_LR_BIT + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FIRE   = 2'd2
  } state_t;

  typedef struct packed {
    logic                valid;
    logic [C_KEY_W-1:0]  key;
    logic                lr;
    logic [C_DATA_W-1:0] data;
  } entry_t;

  function automatic logic [C_KEY_W-1:0] key_make(
    input logic [C_COLOR_W-1:0] color,
    input logic [C_GEN_W-1:0]   gen,
    input logic [C_DEST_W-1:0]  dest
  );
    logic [C_KEY_W-1:0] k;
    k = '0;
    k[C_COLOR_LSB +: C_COLOR_W] = color;
    k[C_GEN_LSB   +: C_GEN_W]   = gen;
    k[C_DEST_LSB  +: C_DEST_W]  = dest;
    return k;
  endfunction

  function automatic entry_t tok_to_entry(input logic [C_TOK_W-1:0] tok);
    entry_t e;
    e.valid = 1'b1;
    e.key   = tok[C_TOK_KEY_LSB +: C_KEY_W];
    e.lr    = tok[C_TOK_LR_BIT];
    e.data  = tok[C_TOK_DATA_LSB +: C_DATA_W];
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmcam_pri_enc.sv
`default_nettype none
// ============================================================================
// Module  : mmcam_pri_enc
// Brief   : Lowest-index-first priority encoder with found flag.
// Revision: 1.0 - initial release
// ============================================================================
module mmcam_pri_enc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         i_req,
  output logic [$clog2(WIDTH)-1:0] o_idx,
  output logic                     o_found
);

  localparam int c_IDX_W = $clog2(WIDTH);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = c_IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmcam_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mmcam_match_ctrl
// Brief   : Matching-memory CAM controller: pairs L/R tokens sharing a key,
//           stores unmatched tokens, emits fired operand pairs.
// Revision: 1.0 - initial release
// ============================================================================
module mmcam_match_ctrl
  import mmcam_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int KEY_W  = C_KEY_W,
  parameter int DATA_W = C_DATA_W
) (
  input  logic                       CP,
  input  logic                       MR,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [KEY_W-1:0]           IN_KEY,
  input  logic                       IN_LR,
  input  logic [DATA_W-1:0]          IN_DATA,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [KEY_W-1:0]           OUT_KEY,
  output logic [DATA_W-1:0]          OUT_DATA_L,
  output logic [DATA_W-1:0]          OUT_DATA_R,
  input  logic                       FLUSH,
  input  logic                       OVF_CLR,
  output logic                       OVERFLOW,
  output logic [$clog2(DEPTH+1)-1:0] COUNT
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  state_t r_state;
  state_t w_state_nxt;

  logic [KEY_W-1:0]  r_hold_key;
  logic              r_hold_lr;
  logic [DATA_W-1:0] r_hold_data;

  logic [DEPTH-1:0]  r_valid;
  logic [KEY_W-1:0]  r_key  [DEPTH];
  logic [DEPTH-1:0]  r_lr;
  logic [DATA_W-1:0] r_data [DEPTH];

  logic               r_out_valid;
  logic [KEY_W-1:0]   r_out_key;
  logic [DATA_W-1:0]  r_out_l;
  logic [DATA_W-1:0]  r_out_r;
  logic               r_ovf;
  logic [c_CNT_W-1:0] r_count;

  logic [DEPTH-1:0]   w_hit_vec;
  logic [DEPTH-1:0]   w_free_vec;
  logic [c_IDX_W-1:0] w_hit_idx;
  logic [c_IDX_W-1:0] w_free_idx;
  logic               w_hit_found;
  logic               w_free_found;
  logic               w_accept;
  logic               w_flush;
  logic               w_fire;
  logic               w_store;
  logic               w_drop;
  logic               w_handshake;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign w_hit_vec[gi] = r_valid[gi] && (r_key[gi] == r_hold_key) && (r_lr[gi] != r_hold_lr);
  end

  assign w_free_vec = ~r_valid;

  mmcam_pri_enc #(.WIDTH(DEPTH)) u_hit_enc (
    .i_req   (w_hit_vec),
    .o_idx   (w_hit_idx),
    .o_found (w_hit_found)
  );

  mmcam_pri_enc #(.WIDTH(DEPTH)) u_free_enc (
    .i_req   (w_free_vec),
    .o_idx   (w_free_idx),
    .o_found (w_free_found)
  );

  assign w_accept    = (r_state == IDLE) && IN_VALID;
  assign w_flush     = (r_state == IDLE) && !IN_VALID && FLUSH;
  assign w_fire      = (r_state == LOOKUP) && w_hit_found;
  assign w_store     = (r_state == LOOKUP) && !w_hit_found && w_free_found;
  assign w_drop      = (r_state == LOOKUP) && !w_hit_found && !w_free_found;
  assign w_handshake = (r_state == FIRE) && r_out_valid && OUT_READY;

  // IN_READY is gated by MR so the source sees "not ready" while held in reset.
  always_comb begin
    w_state_nxt = r_state;
    IN_READY    = 1'b0;
    case (r_state)
      IDLE: begin
        IN_READY = MR;
        if (IN_VALID) w_state_nxt = LOOKUP;
      end
      LOOKUP:  w_state_nxt = w_hit_found ? FIRE : IDLE;
      FIRE:    if (OUT_READY) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_key   <= '0;
      r_out_l     <= '0;
      r_out_r     <= '0;
    end else begin
      r_state <= w_state_nxt;
      // A new drop outranks a simultaneous clear.
      r_ovf   <= w_drop | (r_ovf & ~OVF_CLR);

      if (w_flush) begin
        r_valid <= '0;
        r_count <= '0;
      end else if (w_store) begin
        r_valid[w_free_idx] <= 1'b1;
        r_count             <= r_count + c_CNT_ONE;
      end else if (w_fire) begin
        r_valid[w_hit_idx] <= 1'b0;
        r_count            <= r_count - c_CNT_ONE;
      end

      if (w_fire) begin
        r_out_valid <= 1'b1;
        r_out_key   <= r_hold_key;
        r_out_l     <= r_hold_lr ? r_data[w_hit_idx] : r_hold_data;
        r_out_r     <= r_hold_lr ? r_hold_data : r_data[w_hit_idx];
      end else if (w_handshake) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Payload storage carries no reset; validity lives in r_valid.
  always_ff @(posedge CP) begin
    if (w_accept) begin
      r_hold_key  <= IN_KEY;
      r_hold_lr   <= IN_LR;
      r_hold_data <= IN_DATA;
    end
    if (w_store) begin
      r_key[w_free_idx]  <= r_hold_key;
      r_lr[w_free_idx]   <= r_hold_lr;
      r_data[w_free_idx] <= r_hold_data;
    end
  end

  assign OUT_VALID  = r_out_valid;
  assign OUT_KEY    = r_out_key;
  assign OUT_DATA_L = r_out_l;
  assign OUT_DATA_R = r_out_r;
  assign OVERFLOW   = r_ovf;
  assign COUNT      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mmcam_match_ctrl.sv
`default_nettype none
// Bench for mmcam_match_ctrl: directed vector table, hand-written corner
// sequences, then random tokens checked against a slot-array model.
module tb_mmcam_match_ctrl;

  localparam int DEPTH  = 8;
  localparam int KEY_W  = 18;
  localparam int DATA_W = 16;
  localparam int OP_TOK = 0, OP_FLUSH = 1, OP_CLR = 2;

  logic              clk = 1'b0;
  logic              mr;
  logic              in_valid, in_ready, in_lr;
  logic [KEY_W-1:0]  in_key, out_key;
  logic [DATA_W-1:0] in_data, out_data_l, out_data_r;
  logic              out_valid, out_ready, flush, ovf_clr, overflow;
  logic [3:0]        count;

  always #5 clk = ~clk;

  mmcam_match_ctrl #(.DEPTH(DEPTH), .KEY_W(KEY_W), .DATA_W(DATA_W)) dut (
    .CP(clk), .MR(mr),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_KEY(in_key), .IN_LR(in_lr), .IN_DATA(in_data),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_KEY(out_key),
    .OUT_DATA_L(out_data_l), .OUT_DATA_R(out_data_r),
    .FLUSH(flush), .OVF_CLR(ovf_clr), .OVERFLOW(overflow), .COUNT(count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: DEPTH numbered slots, lowest index preferred for both
  // partner search and free-slot allocation.
  logic              m_valid [DEPTH];
  logic [KEY_W-1:0]  m_key   [DEPTH];
  logic              m_lr    [DEPTH];
  logic [DATA_W-1:0] m_data  [DEPTH];
  logic              m_ovf;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  task automatic model_tok(input logic [KEY_W-1:0] k, input logic lr, input logic [DATA_W-1:0] d,
                           input logic clr, output logic fire,
                           output logic [DATA_W-1:0] l, output logic [DATA_W-1:0] r);
    int hit = -1;
    int fr  = -1;
    logic set = 1'b0;
    fire = 1'b0; l = '0; r = '0;
    for (int i = 0; i < DEPTH; i++)
      if (hit < 0 && m_valid[i] && m_key[i] == k && m_lr[i] != lr) hit = i;
    if (hit >= 0) begin
      fire = 1'b1;
      l = lr ? m_data[hit] : d;
      r = lr ? d : m_data[hit];
      m_valid[hit] = 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) if (fr < 0 && !m_valid[i]) fr = i;
      if (fr >= 0) begin
        m_valid[fr] = 1'b1; m_key[fr] = k; m_lr[fr] = lr; m_data[fr] = d;
      end else begin
        set = 1'b1;
      end
    end
    m_ovf = set | (m_ovf & ~clr);
  endtask

  // Drives one token from IDLE, checks it against the model, and completes
  // the output handshake after `stall` cycles of OUT_READY=0.
  task automatic apply(input logic [KEY_W-1:0] k, input logic lr, input logic [DATA_W-1:0] d,
                       input logic fl, input logic clr, input int stall,
                       output logic o_fire, output logic [KEY_W-1:0] o_key,
                       output logic [DATA_W-1:0] o_l, output logic [DATA_W-1:0] o_r,
                       output int o_cnt, output logic o_ovf);
    logic e_fire;
    logic [DATA_W-1:0] e_l, e_r;
    int e_cnt;
    int w = 0;
    while (!in_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    chk("idle_ready", in_ready, 1);
    model_tok(k, lr, d, clr, e_fire, e_l, e_r);
    e_cnt = model_count();
    in_valid = 1'b1; in_key = k; in_lr = lr; in_data = d; flush = fl;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; ovf_clr = clr;
    chk("lookup_ready", in_ready, 0);
    chk("lookup_out_valid", out_valid, 0);
    @(negedge clk);
    ovf_clr = 1'b0;
    o_fire = out_valid; o_key = out_key; o_l = out_data_l; o_r = out_data_r;
    o_cnt = int'(count); o_ovf = overflow;
    chk("model_fire", out_valid, e_fire);
    chk("model_count", count, e_cnt);
    chk("model_ovf", overflow, m_ovf);
    if (e_fire) begin
      chk("model_key", out_key, k);
      chk("model_l", out_data_l, e_l);
      chk("model_r", out_data_r, e_r);
      chk("fire_ready", in_ready, 0);
    end
    if (out_valid) begin
      if (e_fire) begin
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("stall_valid", out_valid, 1);
          chk("stall_ready", in_ready, 0);
          chk("stall_key", out_key, k);
          chk("stall_l", out_data_l, e_l);
          chk("stall_r", out_data_r, e_r);
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("hs_valid_low", out_valid, 0);
      chk("hs_idle_ready", in_ready, 1);
    end
  endtask

  task automatic do_flush();
    chk("flush_ready", in_ready, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
    chk("flush_count", count, model_count());
  endtask

  task automatic do_clr();
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    m_ovf = 1'b0;
    chk("clr_ovf", overflow, m_ovf);
  endtask

  typedef struct {
    int                op;
    logic [KEY_W-1:0]  key;
    logic              lr;
    logic [DATA_W-1:0] data;
    logic              fl;
    logic              clr;
    logic              exp_fire;
    logic [DATA_W-1:0] exp_l;
    logic [DATA_W-1:0] exp_r;
    int                exp_cnt;
    logic              exp_ovf;
  } vec_t;

  vec_t tbl [40];
  int   n_tbl = 0;

  task automatic add(input int op, input logic [KEY_W-1:0] k, input logic lr, input logic [DATA_W-1:0] d,
                     input logic fl, input logic clr, input logic f,
                     input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, input int c, input logic o);
    tbl[n_tbl].op = op;   tbl[n_tbl].key = k;   tbl[n_tbl].lr = lr;  tbl[n_tbl].data = d;
    tbl[n_tbl].fl = fl;   tbl[n_tbl].clr = clr; tbl[n_tbl].exp_fire = f;
    tbl[n_tbl].exp_l = l; tbl[n_tbl].exp_r = r; tbl[n_tbl].exp_cnt = c; tbl[n_tbl].exp_ovf = o;
    n_tbl++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic f, o;
    logic [KEY_W-1:0] k;
    logic [DATA_W-1:0] l, r;
    int c;

    // op key lr data fl clr | fire L R count ovf
    add(OP_TOK, 18'h000A5, 0, 16'h1111, 0, 0, 0, 16'h0,    16'h0,    1, 0);
    add(OP_TOK, 18'h000A5, 1, 16'h2222, 0, 0, 1, 16'h1111, 16'h2222, 0, 0);
    add(OP_TOK, 18'h00001, 0, 16'h0003, 0, 0, 0, 16'h0,    16'h0,    1, 0);
    add(OP_TOK, 18'h00002, 1, 16'h0004, 0, 0, 0, 16'h0,    16'h0,    2, 0);
    add(OP_TOK, 18'h00001, 0, 16'h0005, 0, 0, 0, 16'h0,    16'h0,    3, 0);
    add(OP_TOK, 18'h00002, 0, 16'h0006, 0, 0, 1, 16'h0006, 16'h0004, 2, 0);
    add(OP_TOK, 18'h00007, 1, 16'h0007, 0, 0, 0, 16'h0,    16'h0,    3, 0);
    add(OP_TOK, 18'h00008, 1, 16'h0008, 0, 0, 0, 16'h0,    16'h0,    4, 0);
    add(OP_FLUSH, '0, 0, '0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(OP_TOK, 18'h00100 + 18'(i), 0, 16'h3000 + 16'(i), 0, 0, 0, 16'h0, 16'h0, i + 1, 0);
    add(OP_TOK, 18'h001FF, 0, 16'h5555, 0, 0, 0, 16'h0,    16'h0,    8, 1);
    add(OP_TOK, 18'h001FE, 0, 16'h6666, 0, 1, 0, 16'h0,    16'h0,    8, 1);
    add(OP_TOK, 18'h00103, 1, 16'h4444, 0, 0, 1, 16'h3003, 16'h4444, 7, 1);
    add(OP_CLR, '0, 0, '0, 0, 0, 0, 16'h0, 16'h0, 7, 0);
    add(OP_FLUSH, '0, 0, '0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
    add(OP_TOK, 18'h00010, 0, 16'hAAAA, 0, 0, 0, 16'h0,    16'h0,    1, 0);
    add(OP_TOK, 18'h00010, 0, 16'hBBBB, 0, 0, 0, 16'h0,    16'h0,    2, 0);
    add(OP_TOK, 18'h00010, 1, 16'hCCCC, 0, 0, 1, 16'hAAAA, 16'hCCCC, 1, 0);
    add(OP_TOK, 18'h00020, 0, 16'h1234, 1, 0, 0, 16'h0,    16'h0,    2, 0);
    add(OP_FLUSH, '0, 0, '0, 0, 0, 0, 16'h0, 16'h0, 0, 0);

    mr = 1'b0; in_valid = 1'b0; in_key = '0; in_lr = 1'b0; in_data = '0;
    out_ready = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
    m_ovf = 1'b0;
    model_clear();
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_key", out_key, 0);
    chk("rst_out_l", out_data_l, 0);
    chk("rst_out_r", out_data_r, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_count", count, 0);
    repeat (2) @(negedge clk);
    mr = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);

    for (int i = 0; i < n_tbl; i++) begin
      case (tbl[i].op)
        OP_TOK: begin
          apply(tbl[i].key, tbl[i].lr, tbl[i].data, tbl[i].fl, tbl[i].clr, 0, f, k, l, r, c, o);
          chk($sformatf("tbl%0d_fire", i), f, tbl[i].exp_fire);
          if (tbl[i].exp_fire) begin
            chk($sformatf("tbl%0d_key", i), k, tbl[i].key);
            chk($sformatf("tbl%0d_l", i), l, tbl[i].exp_l);
            chk($sformatf("tbl%0d_r", i), r, tbl[i].exp_r);
          end
          chk($sformatf("tbl%0d_count", i), c, tbl[i].exp_cnt);
          chk($sformatf("tbl%0d_ovf", i), o, tbl[i].exp_ovf);
        end
        OP_FLUSH: begin
          do_flush();
          chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_cnt);
          chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].exp_ovf);
        end
        default: begin
          do_clr();
          chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_cnt);
          chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].exp_ovf);
        end
      endcase
    end

    // Backpressure: five stalled cycles, then exactly one handshake.
    apply(18'h00300, 0, 16'h7777, 0, 0, 0, f, k, l, r, c, o);
    apply(18'h00300, 1, 16'h8888, 0, 0, 5, f, k, l, r, c, o);
    chk("bp_fire", f, 1);
    chk("bp_l", l, 16'h7777);
    chk("bp_r", r, 16'h8888);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_single_hs", out_valid, 0);
    chk("bp_count", count, 0);

    // Asynchronous reset while a fired pair is pending.
    apply(18'h00ABC, 0, 16'h0101, 0, 0, 0, f, k, l, r, c, o);
    apply(18'h00ABD, 0, 16'h0303, 0, 0, 0, f, k, l, r, c, o);
    in_valid = 1'b1; in_key = 18'h00ABC; in_lr = 1'b1; in_data = 16'h0202;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("arst_pre_valid", out_valid, 1);
    chk("arst_pre_count", count, 1);
    #2 mr = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_in_ready", in_ready, 0);
    @(negedge clk);
    mr = 1'b1;
    model_clear();
    m_ovf = 1'b0;
    @(negedge clk);
    chk("arst_release_ready", in_ready, 1);
    chk("arst_release_count", count, 0);

    // Randomized tokens over a small key space so hits, duplicates and
    // occasional fills all occur.
    for (int t = 0; t < 300; t++) begin
      int sel;
      sel = int'($urandom_range(0, 49));
      if (sel == 0) do_flush();
      else if (sel == 1) do_clr();
      else
        apply(18'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 16'($urandom),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, 3)), f, k, l, r, c, o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
